pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset (word-aligned).
REQ-002 SHALL have parameter COUNT_W, default 16, width of retired-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port stall  input  1  hold PC and counter this cycle.
REQ-007 SHALL have port instruction  input  32  word returned by instruction memory for current pc (combinational path, same cycle).
REQ-008 SHALL have port branch_cond  input  1  beq comparison result (rs == rt) from datapath.
REQ-009 SHALL have port pc  output  32  registered fetch address driven to instruction memory.
REQ-010 SHALL have port pc_plus4  output  32  pc + 4, combinational.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port halted  output  1  high while in HALT.
REQ-013 SHALL have port retired_count  output  COUNT_W  instructions retired since reset.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, HALT; running/halted decoded from state (Moore).
REQ-015 IDLE: pc holds; start=1 -> RUN at next edge; no instruction retires in IDLE.
REQ-016 RUN, stall=0: one instruction retires per cycle; pc <= next_pc; retired_count += 1.
REQ-017 next_pc, by opcode instruction[31:26]:
  - 6'b110000 (beq) with branch_cond=1: pc_plus4 + (sign-extended instruction[15:0] << 2).
  - 6'b110000 with branch_cond=0: pc_plus4.
  - 6'b110010 (jump): {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - 6'b111111 (halt): pc holds; state -> HALT; halt counts as retired.
  - any other opcode: pc_plus4.
REQ-018 branch_cond SHALL be ignored for every opcode other than beq.
REQ-019 RUN, stall=1: pc, retired_count, state all hold; halt opcode not acted on until stall drops.
REQ-020 HALT: pc and retired_count hold; start and stall ignored; exit only via rst.
REQ-021 start SHALL be ignored in RUN and HALT.
REQ-022 All PC arithmetic modulo 2^32: pc 32'hFFFF_FFFC sequential -> 32'h0000_0000.
REQ-023 retired_count SHALL wrap from all-ones to 0.
REQ-024 pc[1:0] SHALL always be 2'b00.

Reset
REQ-025 On rst=1, immediately and regardless of clk: state=IDLE, pc=RESET_PC, retired_count=0, running=0, halted=0.
REQ-026 rst asserted mid-RUN or in HALT SHALL abort without completing the in-flight instruction; after release, stays IDLE until start.

Structure
REQ-027 Opcode constants (BEQ, JUMP, HALT, plus ALU/memory opcodes) and FSM state encoding SHALL live in shared package mips_isa_pkg.
REQ-028 Next-PC computation SHALL be a combinational sub-module npc_calc (inputs pc_plus4, instruction, branch_cond; output next_pc).
REQ-029 Only the state register, pc and retired_count SHALL be sequential.

Verification
REQ-030 Reset then start, NOP stream (opcode 000000), no stall -> pc 0,4,8,12 on successive cycles; retired_count 1,2,3.
REQ-031 pc=12, instruction=32'hC043FFFE, branch_cond=1 -> pc=8; same with branch_cond=0 -> pc=16.
REQ-032 pc=20, instruction=32'hC800_0000 (jump 0) -> pc=0; instruction 32'hC800_0004 -> pc=16.
REQ-033 pc=40, instruction=32'hFC00_0000 -> halted=1, running=0, pc stays 40 for 10 cycles, start pulses ignored, count frozen.
REQ-034 stall=1 for 3 cycles at pc=8 with halt opcode present -> pc=8, count unchanged, no HALT; stall drop -> HALT next edge.
REQ-035 rst pulse between clock edges while RUN at pc=24 -> pc=0, state IDLE, count=0 before next edge; pc wrap 32'hFFFF_FFFC -> 0.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared ISA opcode constants and fetch-FSM state encoding.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_JUMP  = 6'b110010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, taken beq, or absolute jump.
module npc_calc
  import mips_isa_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instruction,
  input  logic        branch_cond,
  output logic [31:0] next_pc
);

  logic [5:0]  w_op;
  logic [31:0] w_br_off;

  assign w_op     = instruction[31:26];
  assign w_br_off = {{14{instruction[15]}}, instruction[15:0], 2'b00};

  // branch_cond only matters for beq; every other opcode falls through
  always_comb begin
    next_pc = pc_plus4;
    case (w_op)
      OP_BEQ:  if (branch_cond) next_pc = pc_plus4 + w_br_off;
      OP_JUMP: next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch sequencer: IDLE/RUN/HALT FSM driving a word-aligned PC and a retire counter.
module pc_fetch_unit
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic [31:0]        instruction,
  input  logic               branch_cond,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] retired_count
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  fetch_state_t       r_state, w_state_nxt;
  logic [31:0]        r_pc;
  logic [COUNT_W-1:0] r_count;
  logic [31:0]        w_pc_plus4, w_next_pc;
  logic               w_retire, w_is_halt;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_retire   = (r_state == ST_RUN) && !stall;
  assign w_is_halt  = (instruction[31:26] == OP_HALT);

  npc_calc u_npc (
    .pc_plus4    (w_pc_plus4),
    .instruction (instruction),
    .branch_cond (branch_cond),
    .next_pc     (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_retire && w_is_halt) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // halt retires but leaves the PC pointing at itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC_AL;
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + 1'b1;
      if (!w_is_halt) r_pc <= w_next_pc;
    end
  end

  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign running       = (r_state == ST_RUN);
  assign halted        = (r_state == ST_HALT);
  assign retired_count = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; a second narrow-counter instance covers counter wrap.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst2 = 1'b1;
  logic        start = 1'b0, start2 = 1'b0, stall = 1'b0, branch_cond = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [31:0] pc, pc_plus4, pc2, pc_plus4_2;
  logic        running, halted, running2, halted2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  int          errors = 0, checks = 0;
  logic [49:0] obs, expv;

  always #5 clk = ~clk;

  pc_fetch_unit u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .instruction(instruction),
    .branch_cond(branch_cond), .pc(pc), .pc_plus4(pc_plus4), .running(running),
    .halted(halted), .retired_count(cnt)
  );

  pc_fetch_unit #(.RESET_PC(32'h0000_0100), .COUNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .stall(stall), .instruction(instruction),
    .branch_cond(branch_cond), .pc(pc2), .pc_plus4(pc_plus4_2), .running(running2),
    .halted(halted2), .retired_count(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    obs = {pc, cnt, running, halted}; expv = {32'h0, 16'h0, 1'b0, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, expv); end
    checks++;
    if (pc_plus4 !== 32'd4) begin errors++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'd4); end
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();
    obs = {pc, cnt, running, halted}; expv = {32'h0, 16'h0, 1'b0, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL idle_hold got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_nop_stream();
    start = 1'b1; tick(); start = 1'b0;
    obs = {pc, cnt, running, halted}; expv = {32'h0, 16'h0, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL start_run got=%h exp=%h", obs, expv); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      obs = {pc, cnt, running, halted}; expv = {32'(4 * i), 16'(i), 1'b1, 1'b0};
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL nop_step%0d got=%h exp=%h", i, obs, expv); end
    end
  endtask

  task automatic test_branch();
    instruction = 32'hC043_FFFE; branch_cond = 1'b1; tick();
    obs = {pc, cnt, running, halted}; expv = {32'd8, 16'd4, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL beq_taken got=%h exp=%h", obs, expv); end
    instruction = 32'h0; branch_cond = 1'b0; tick();
    instruction = 32'hC043_FFFE; tick();
    obs = {pc, cnt, running, halted}; expv = {32'd16, 16'd6, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL beq_not_taken got=%h exp=%h", obs, expv); end
    instruction = 32'h0000_FFFE; branch_cond = 1'b1; tick();
    obs = {pc, cnt, running, halted}; expv = {32'd20, 16'd7, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL cond_ignored got=%h exp=%h", obs, expv); end
    branch_cond = 1'b0;
  endtask

  task automatic test_jump();
    instruction = 32'hC800_0000; tick();
    obs = {pc, cnt, running, halted}; expv = {32'd0, 16'd8, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL jump0 got=%h exp=%h", obs, expv); end
    instruction = 32'hC800_0004; tick();
    obs = {pc, cnt, running, halted}; expv = {32'd16, 16'd9, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL jump4 got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_stall();
    instruction = 32'hC000_FFFD; branch_cond = 1'b1; tick();
    branch_cond = 1'b0;
    instruction = 32'hFC00_0000; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {pc, cnt, running, halted}; expv = {32'd8, 16'd10, 1'b1, 1'b0};
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, expv); end
    end
    stall = 1'b0; tick();
    obs = {pc, cnt, running, halted}; expv = {32'd8, 16'd11, 1'b0, 1'b1};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL stall_release_halt got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_halt();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    instruction = 32'hC800_000A; tick();
    instruction = 32'hFC00_0000; tick();
    obs = {pc, cnt, running, halted}; expv = {32'd40, 16'd2, 1'b0, 1'b1};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL halt_enter got=%h exp=%h", obs, expv); end
    for (int i = 0; i < 10; i++) begin
      start = i[0]; stall = i[1]; branch_cond = 1'b1;
      instruction = i[2] ? 32'hC800_0004 : 32'h0;
      tick();
      obs = {pc, cnt, running, halted}; expv = {32'd40, 16'd2, 1'b0, 1'b1};
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL halt_hold%0d got=%h exp=%h", i, obs, expv); end
    end
    start = 1'b0; stall = 1'b0; branch_cond = 1'b0; instruction = 32'h0;
  endtask

  task automatic test_async_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    obs = {pc, cnt, running, halted}; expv = {32'd24, 16'd6, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL pre_reset_run got=%h exp=%h", obs, expv); end
    #2 rst = 1'b1;
    #1;
    obs = {pc, cnt, running, halted}; expv = {32'd0, 16'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs, expv); end
    #1 rst = 1'b0;
    tick(); tick();
    obs = {pc, cnt, running, halted}; expv = {32'd0, 16'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL post_reset_idle got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_wrap();
    start = 1'b1; tick(); start = 1'b0;
    instruction = 32'hC000_FFFE; branch_cond = 1'b1; tick();
    obs = {pc, cnt, running, halted}; expv = {32'hFFFF_FFFC, 16'd1, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL to_top got=%h exp=%h", obs, expv); end
    checks++;
    if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL plus4_wrap got=%h exp=%h", pc_plus4, 32'h0); end
    instruction = 32'h0; branch_cond = 1'b0; tick();
    obs = {pc, cnt, running, halted}; expv = {32'h0, 16'd2, 1'b1, 1'b0};
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL pc_wrap got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_count_wrap();
    rst = 1'b1; rst2 = 1'b0; instruction = 32'h0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    checks++;
    if ({pc2, cnt2, running2} !== {32'h100, 2'd0, 1'b1}) begin
      errors++; $display("FAIL narrow_start got=%h/%0d exp=100/0", pc2, cnt2);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({pc2, cnt2} !== {32'h100 + 32'(4 * i), 2'(i % 4)}) begin
        errors++; $display("FAIL count_wrap%0d got=%h/%0d exp=%h/%0d", i, pc2, cnt2, 32'h100 + 32'(4 * i), i % 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_branch();
    test_jump();
    test_stall();
    test_halt();
    test_async_reset();
    test_wrap();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
